// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package fetch_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT
   } fetch_state_t;

endpackage

// File: rtl/branch_target_adder.sv
// Combinational branch target: base + sign-extended offset, with word-alignment flag.
// Shared with the execute-stage branch unit.
module branch_target_adder
   import fetch_pkg::*;
(
   input  logic [XLEN-1:0] base_i,
   input  logic [XLEN-1:0] offset_i,
   output logic [XLEN-1:0] target_o,
   output logic            misaligned_o
);

   // Wrap-around modulo 2^XLEN is intended; no carry out is kept.
   assign target_o     = base_i + offset_i;
   assign misaligned_o = (target_o[1:0] != 2'b00);

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem request/response,
// registered valid/ready output slot to decode, and taken-branch redirect handling.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
)
(
   input  logic            clk,
   input  logic            rst_n,

   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,

   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic [XLEN-1:0] redirect_imm,

   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_instr,

   output logic            misalign_fault
);

   localparam logic [XLEN-1:0] INSTR_STEP = XLEN'(INSTR_BYTES);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic            kill_q, kill_d;
   logic            if_valid_q, if_valid_d;
   logic [XLEN-1:0] if_pc_q, if_pc_d;
   logic [XLEN-1:0] if_instr_q, if_instr_d;
   logic            fault_q, fault_d;

   logic [XLEN-1:0] target;
   logic            target_misaligned;
   logic            req_hs;
   logic            redirect_ok;

   branch_target_adder u_target (
      .base_i       (redirect_pc),
      .offset_i     (redirect_imm),
      .target_o     (target),
      .misaligned_o (target_misaligned)
   );

   // Requests only go out when the slot will be free, so a response never finds it occupied.
   assign imem_req_valid = (state_q == REQ) && (!if_valid_q || if_ready);
   assign imem_req_addr  = pc_q;
   assign req_hs         = imem_req_valid && imem_req_ready;
   assign redirect_ok    = redirect_valid && !target_misaligned;

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path can infer a latch.
      state_d    = state_q;
      pc_d       = pc_q;
      fetch_pc_d = fetch_pc_q;
      kill_d     = kill_q;
      if_valid_d = if_valid_q && !if_ready;
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;
      fault_d    = redirect_valid && target_misaligned;

      unique case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (req_hs) begin
               state_d    = WAIT;
               fetch_pc_d = pc_q;
               pc_d       = pc_q + INSTR_STEP;
            end
         end
         WAIT: begin
            if (imem_rsp_valid) begin
               state_d = REQ;
               kill_d  = 1'b0;
               // Any redirect this cycle (aligned or not) flushes the arriving word.
               if (!kill_q && !redirect_valid) begin
                  if_valid_d = 1'b1;
                  if_pc_d    = fetch_pc_q;
                  if_instr_d = imem_rsp_data;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (redirect_valid) begin
         if_valid_d = 1'b0;
      end

      // A fetch issued or still pending at redirect time is wrong-path and must be dropped.
      if (redirect_ok) begin
         pc_d = target;
         if (state_q == REQ && req_hs) begin
            kill_d = 1'b1;
         end else if (state_q == WAIT && !imem_rsp_valid) begin
            kill_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         fetch_pc_q <= RESET_PC;
         kill_q     <= 1'b0;
         if_valid_q <= 1'b0;
         if_pc_q    <= '0;
         if_instr_q <= '0;
         fault_q    <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         state_q    <= state_d;
         pc_q       <= pc_d;
         fetch_pc_q <= fetch_pc_d;
         kill_q     <= kill_d;
         if_valid_q <= if_valid_d;
         if_pc_q    <= if_pc_d;
         if_instr_q <= if_instr_d;
         fault_q    <= fault_d;
      end
   end

   assign if_valid       = if_valid_q;
   assign if_pc          = if_pc_q;
   assign if_instr       = if_instr_q;
   assign misalign_fault = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory responder, transaction-level reference model checked
// every cycle, and directed scenarios with literal expectations.
module tb_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk;
   logic        rst_n;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] redirect_imm;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        misalign_fault;

   fetch_stage #(.RESET_PC(RST_PC)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .redirect_imm   (redirect_imm),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .misalign_fault (misalign_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // Instruction memory: one outstanding request, fixed latency, optional stray pulse.
   int          mem_lat = 1;
   int          mem_cnt = 0;
   logic [31:0] mem_pend;
   logic        mem_hs;
   logic [31:0] mem_addr;
   bit          stray_req = 1'b0;

   initial begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         mem_hs   = rst_n && imem_req_valid && imem_req_ready;
         mem_addr = imem_req_addr;
         @(posedge clk);
         #1;
         imem_rsp_valid = 1'b0;
         if (!rst_n) begin
            mem_cnt = 0;
         end else begin
            if (mem_hs) begin
               mem_pend = mem_addr;
               mem_cnt  = mem_lat;
            end
            if (mem_cnt != 0) begin
               mem_cnt--;
               if (mem_cnt == 0) begin
                  imem_rsp_valid = 1'b1;
                  imem_rsp_data  = mem_word(mem_pend);
               end
            end else if (stray_req) begin
               stray_req      = 1'b0;
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = 32'hDEAD_BEEF;
            end
         end
      end
   end

   // Reference model: next fetch address, one in-flight fetch with a wrong-path flag,
   // and the expected contents of the decode slot.
   logic        m_started, m_slot_v, m_fault, m_inf_v, m_inf_kill;
   logic [31:0] m_fetch_pc, m_slot_pc, m_inf_pc;
   logic        exp_req, hs, rsp, al, mis;
   logic [31:0] tgt;
   logic [31:0] issue_log[$];
   logic [31:0] deliv_log[$];
   int          fault_cnt = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            check("rst_req_valid", 32'(imem_req_valid), 32'd0);
            check("rst_req_addr", imem_req_addr, RST_PC);
            check("rst_if_valid", 32'(if_valid), 32'd0);
            check("rst_if_pc", if_pc, 32'd0);
            check("rst_if_instr", if_instr, 32'd0);
            check("rst_fault", 32'(misalign_fault), 32'd0);
            m_started  = 1'b0;
            m_slot_v   = 1'b0;
            m_fault    = 1'b0;
            m_inf_v    = 1'b0;
            m_inf_kill = 1'b0;
            m_fetch_pc = RST_PC;
            m_slot_pc  = '0;
            m_inf_pc   = '0;
         end else begin
            exp_req = m_started && !m_inf_v && (!m_slot_v || if_ready);
            check("if_valid", 32'(if_valid), 32'(m_slot_v));
            if (m_slot_v) begin
               check("if_pc", if_pc, m_slot_pc);
               check("if_instr", if_instr, mem_word(m_slot_pc));
            end
            check("req_valid", 32'(imem_req_valid), 32'(exp_req));
            if (exp_req) check("req_addr", imem_req_addr, m_fetch_pc);
            check("misalign_fault", 32'(misalign_fault), 32'(m_fault));

            if (misalign_fault) fault_cnt++;
            if (if_valid && if_ready) deliv_log.push_back(if_pc);
            if (imem_req_valid && imem_req_ready) issue_log.push_back(imem_req_addr);

            hs  = exp_req && imem_req_ready;
            tgt = redirect_pc + redirect_imm;
            al  = redirect_valid && (tgt[1:0] == 2'b00);
            mis = redirect_valid && (tgt[1:0] != 2'b00);
            rsp = imem_rsp_valid && m_inf_v;

            if (redirect_valid) m_slot_v = 1'b0;
            else if (rsp && !m_inf_kill) begin
               m_slot_v  = 1'b1;
               m_slot_pc = m_inf_pc;
            end else if (m_slot_v && if_ready) m_slot_v = 1'b0;
            if (rsp) m_inf_v = 1'b0;
            if (hs) begin
               m_inf_v    = 1'b1;
               m_inf_pc   = m_fetch_pc;
               m_inf_kill = 1'b0;
               m_fetch_pc = m_fetch_pc + 32'd4;
            end
            if (al) begin
               m_fetch_pc = tgt;
               if (m_inf_v) m_inf_kill = 1'b1;
            end
            m_fault   = mis;
            m_started = 1'b1;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_hs(input string name);
      for (int i = 0; i < 50; i++) begin
         if (imem_req_valid && imem_req_ready) return;
         step(1);
      end
      check({name, "_hs_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic redirect(input logic [31:0] pc, input logic [31:0] imm);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      redirect_imm   = imm;
      step(1);
      redirect_valid = 1'b0;
   endtask

   task automatic expect_deliv(input string name, input int idx, input logic [31:0] exp);
      for (int i = 0; i < 60 && deliv_log.size() <= idx; i++) step(1);
      if (deliv_log.size() > idx) check(name, deliv_log[idx], exp);
      else check({name, "_timeout"}, 'x, exp);
   endtask

   task automatic expect_issue(input string name, input int idx, input logic [31:0] exp);
      for (int i = 0; i < 60 && issue_log.size() <= idx; i++) step(1);
      if (issue_log.size() > idx) check(name, issue_log[idx], exp);
      else check({name, "_timeout"}, 'x, exp);
   endtask

   task automatic release_reset();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   int d0, i0, f0, k;

   initial begin
      rst_n          = 1'b0;
      imem_req_ready = 1'b1;
      if_ready       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      redirect_imm   = '0;
      release_reset();

      // Straight-line stream from RESET_PC.
      expect_issue("issue0", 0, 32'h100);
      expect_issue("issue1", 1, 32'h104);
      expect_issue("issue2", 2, 32'h108);
      expect_deliv("deliv0", 0, 32'h100);
      expect_deliv("deliv1", 1, 32'h104);

      // Decode back-pressure with a stray response thrown in.
      for (int i = 0; i < 20 && !if_valid; i++) step(1);
      k = deliv_log.size();
      i0 = issue_log.size();
      if_ready  = 1'b0;
      stray_req = 1'b1;
      step(5);
      check("bp_no_request", 32'(issue_log.size() - i0), 32'd0);
      if_ready = 1'b1;
      expect_deliv("bp_resume0", k, RST_PC + 32'(4 * k));
      expect_deliv("bp_resume1", k + 1, RST_PC + 32'(4 * (k + 1)));

      // Redirect in WAIT before the response arrives.
      mem_lat = 3;
      wait_hs("wait_redir");
      step(1);
      i0 = issue_log.size();
      redirect(32'h200, 32'hFFFF_FFF0);
      d0 = deliv_log.size();
      expect_issue("wait_redir_issue", i0, 32'h1F0);
      expect_deliv("wait_redir_deliv", d0, 32'h1F0);

      // Redirect coincident with the response.
      mem_lat = 1;
      wait_hs("rsp_redir");
      step(1);
      redirect(32'h3F0, 32'h10);
      d0 = deliv_log.size();
      expect_deliv("rsp_redir_deliv", d0, 32'h400);

      // Redirect coincident with a request handshake.
      wait_hs("hs_redir");
      redirect(32'h500, 32'hFFFF_FF00);
      d0 = deliv_log.size();
      expect_deliv("hs_redir_deliv0", d0, 32'h400);
      expect_deliv("hs_redir_deliv1", d0 + 1, 32'h404);

      // Misaligned redirect while a fetch to 0x804 is pending.
      mem_lat = 3;
      wait_hs("pre_mis");
      step(1);
      redirect(32'h7F0, 32'h10);
      d0 = deliv_log.size();
      expect_deliv("pre_mis_deliv", d0, 32'h800);
      f0 = fault_cnt;
      redirect(32'h10, 32'h6);
      expect_deliv("mis_deliv0", d0 + 1, 32'h804);
      expect_deliv("mis_deliv1", d0 + 2, 32'h808);
      check("mis_fault_pulses", 32'(fault_cnt - f0), 32'd1);

      // Target wrap-around.
      mem_lat = 1;
      wait_hs("wrap");
      step(1);
      redirect(32'hFFFF_FFFC, 32'h8);
      d0 = deliv_log.size();
      expect_deliv("wrap_deliv0", d0, 32'h4);
      expect_deliv("wrap_deliv1", d0 + 1, 32'h8);

      // Asynchronous reset while waiting for a response.
      mem_lat = 3;
      wait_hs("areset");
      step(1);
      #2 rst_n = 1'b0;
      #1;
      check("areset_req_valid", 32'(imem_req_valid), 32'd0);
      check("areset_req_addr", imem_req_addr, RST_PC);
      check("areset_if_valid", 32'(if_valid), 32'd0);
      check("areset_if_pc", if_pc, 32'd0);
      check("areset_if_instr", if_instr, 32'd0);
      check("areset_fault", 32'(misalign_fault), 32'd0);
      mem_lat = 1;
      i0 = issue_log.size();
      d0 = deliv_log.size();
      release_reset();
      expect_issue("restart_issue", i0, 32'h100);
      expect_deliv("restart_deliv0", d0, 32'h100);
      expect_deliv("restart_deliv1", d0 + 1, 32'h104);

      step(4);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
